// File: rtl/memory_unit.sv
// Memory-interface responder: holds PC and MAR, executes one memory_op per clock
// against a synchronous byte RAM and returns read/fetch data on the shared bus.
package memory_unit_pkg;
  typedef enum logic [2:0] {
    MEM_NOP      = 3'd0,
    MEM_READ     = 3'd1,
    MEM_WRITE    = 3'd2,
    MEM_SET_ADDR = 3'd3,
    MEM_FETCH    = 3'd4,
    MEM_JUMP     = 3'd5,
    MEM_PC_INC   = 3'd6
  } memory_op_e;
endpackage

module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  memory_op_e            memory_op,
  input  logic                  data_word_selector,
  input  logic                  bus_selector,
  input  logic [7:0]            bus_in,
  output logic [7:0]            bus_out,
  output logic                  bus_oe,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  mem_fault
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(DEPTH - 1);

  logic [7:0]            ram [DEPTH];
  logic [7:0]            data_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] mar_q;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] pc_adv;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [IDX_W-1:0]      ram_idx;
  logic                  acc_in_range;
  logic                  ram_we;

  // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
  always_comb begin
    acc_addr = mar_q;
    if (memory_op == MEM_FETCH || data_word_selector) begin
      acc_addr = pc_q;
    end
    acc_in_range = ({1'b0, acc_addr} < DEPTH_V);
    ram_idx      = acc_addr[IDX_W-1:0];
    ram_we       = (memory_op == MEM_WRITE) && acc_in_range;
    // Silent wrap at the last implemented byte; beyond DEPTH it is plain modulo arithmetic.
    pc_adv       = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);
    bus_addr     = ADDR_WIDTH'(bus_in);
  end

  // NOTE: RAM contents are deliberately not reset; only the write is held off while reset_n is low.
  always_ff @(posedge clock) begin
    if (reset_n && ram_we) begin
      ram[ram_idx] <= bus_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      mar_q     <= '0;
      data_q    <= 8'h00;
      mem_fault <= 1'b0;
    end else begin
      case (memory_op)
        MEM_READ: begin
          data_q <= acc_in_range ? ram[ram_idx] : 8'h00;
          if (!acc_in_range) mem_fault <= 1'b1;
        end
        MEM_WRITE: begin
          if (!acc_in_range) mem_fault <= 1'b1;
        end
        MEM_SET_ADDR: mar_q <= bus_addr;
        MEM_FETCH: begin
          data_q <= acc_in_range ? ram[ram_idx] : 8'h00;
          if (!acc_in_range) mem_fault <= 1'b1;
          pc_q <= pc_adv;
        end
        MEM_JUMP:   pc_q <= bus_addr;
        MEM_PC_INC: pc_q <= pc_adv;
        default: ;
      endcase
    end
  end

  // Freshness of data_q is the microcode's job; the bus enable simply follows the control word.
  assign bus_out = data_q;
  assign bus_oe  = bus_selector;
  assign pc      = pc_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench: two memory_unit instances (DEPTH 256 and 200) share stimulus
// and are compared against a behavioural model, a vector table and corner sequences.
module tb_memory_unit;
  import memory_unit_pkg::*;

  localparam logic [2:0] OP_NOP = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2, OP_SET = 3'd3,
                         OP_FETCH = 3'd4, OP_JUMP = 3'd5, OP_INC = 3'd6, OP_RSV = 3'd7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  memory_op_e memory_op = MEM_NOP;
  logic       data_word_selector = 1'b0;
  logic       bus_selector = 1'b0;
  logic [7:0] bus_in = 8'h00;

  logic [7:0] a_bus_out, b_bus_out, a_pc, b_pc;
  logic       a_bus_oe, b_bus_oe, a_fault, b_fault;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural model, index 0 = DEPTH 256, index 1 = DEPTH 200.
  int depth [2] = '{256, 200};
  int m_pc [2], m_mar [2], m_data [2], m_fault [2];
  int m_ram [2][256];

  always #5 clock = ~clock;

  memory_unit #(.ADDR_WIDTH(8), .DEPTH(256)) dut_a (
    .clock(clock), .reset_n(reset_n), .memory_op(memory_op),
    .data_word_selector(data_word_selector), .bus_selector(bus_selector), .bus_in(bus_in),
    .bus_out(a_bus_out), .bus_oe(a_bus_oe), .pc(a_pc), .mem_fault(a_fault)
  );

  memory_unit #(.ADDR_WIDTH(8), .DEPTH(200)) dut_b (
    .clock(clock), .reset_n(reset_n), .memory_op(memory_op),
    .data_word_selector(data_word_selector), .bus_selector(bus_selector), .bus_in(bus_in),
    .bus_out(b_bus_out), .bus_oe(b_bus_oe), .pc(b_pc), .mem_fault(b_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pc[c] = 0; m_mar[c] = 0; m_data[c] = 0; m_fault[c] = 0;
    end
  endtask

  function automatic int advance(input int p, input int d);
    return (p == d - 1) ? 0 : (p + 1) % 256;
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic dws, input logic [7:0] bin);
    for (int c = 0; c < 2; c++) begin
      int a;
      a = dws ? m_pc[c] : m_mar[c];
      case (op)
        OP_READ: begin
          if (a < depth[c]) m_data[c] = m_ram[c][a];
          else begin m_data[c] = 0; m_fault[c] = 1; end
        end
        OP_WRITE: begin
          if (a < depth[c]) m_ram[c][a] = int'(bin);
          else m_fault[c] = 1;
        end
        OP_SET: m_mar[c] = int'(bin);
        OP_FETCH: begin
          if (m_pc[c] < depth[c]) m_data[c] = m_ram[c][m_pc[c]];
          else begin m_data[c] = 0; m_fault[c] = 1; end
          m_pc[c] = advance(m_pc[c], depth[c]);
        end
        OP_JUMP: m_pc[c] = int'(bin);
        OP_INC:  m_pc[c] = advance(m_pc[c], depth[c]);
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("A bus_out", a_bus_out, m_data[0]);
    check("A pc", a_pc, m_pc[0]);
    check("A mem_fault", a_fault, m_fault[0]);
    check("A bus_oe", a_bus_oe, bus_selector);
    check("B bus_out", b_bus_out, m_data[1]);
    check("B pc", b_pc, m_pc[1]);
    check("B mem_fault", b_fault, m_fault[1]);
    check("B bus_oe", b_bus_oe, bus_selector);
  endtask

  // Called at a negedge: drive the control word, let one posedge act, compare, return at next negedge.
  task automatic step(input logic [2:0] op, input logic dws, input logic [7:0] bin, input logic bsel);
    memory_op = memory_op_e'(op);
    data_word_selector = dws;
    bus_in = bin;
    bus_selector = bsel;
    @(posedge clock);
    model_apply(op, dws, bin);
    #2;
    compare_all();
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    memory_op = MEM_NOP;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       dws;
    logic [7:0] bin;
    logic       bsel;
    logic [7:0] exp_out;
    logic [7:0] exp_pc;
    logic       exp_fault;
  } vec_t;

  vec_t vecs [21];

  initial begin
    // Expected values are for the DEPTH=256 instance; RAM pre-filled with (a*7+3) mod 256.
    vecs[0]  = '{OP_SET,   1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{OP_WRITE, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{OP_READ,  1'b0, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[3]  = '{OP_NOP,   1'b0, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b0};
    vecs[4]  = '{OP_SET,   1'b0, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[5]  = '{OP_WRITE, 1'b0, 8'h11, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[6]  = '{OP_SET,   1'b0, 8'h01, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[7]  = '{OP_WRITE, 1'b0, 8'h22, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[8]  = '{OP_SET,   1'b0, 8'h02, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[9]  = '{OP_WRITE, 1'b0, 8'h33, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[10] = '{OP_JUMP,  1'b0, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[11] = '{OP_FETCH, 1'b0, 8'h00, 1'b0, 8'h11, 8'h01, 1'b0};
    vecs[12] = '{OP_FETCH, 1'b1, 8'h00, 1'b0, 8'h22, 8'h02, 1'b0};
    vecs[13] = '{OP_FETCH, 1'b0, 8'h00, 1'b1, 8'h33, 8'h03, 1'b0};
    vecs[14] = '{OP_JUMP,  1'b0, 8'hFF, 1'b0, 8'h33, 8'hFF, 1'b0};
    vecs[15] = '{OP_FETCH, 1'b0, 8'h00, 1'b0, 8'hFC, 8'h00, 1'b0};
    vecs[16] = '{OP_JUMP,  1'b0, 8'h05, 1'b0, 8'hFC, 8'h05, 1'b0};
    vecs[17] = '{OP_WRITE, 1'b1, 8'h9C, 1'b0, 8'hFC, 8'h05, 1'b0};
    vecs[18] = '{OP_FETCH, 1'b0, 8'h00, 1'b0, 8'h9C, 8'h06, 1'b0};
    vecs[19] = '{OP_RSV,   1'b1, 8'h55, 1'b1, 8'h9C, 8'h06, 1'b0};
    vecs[20] = '{OP_INC,   1'b0, 8'h00, 1'b0, 8'h9C, 8'h07, 1'b0};

    model_reset();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 256; a++) m_ram[c][a] = 0;
    @(negedge clock);
    #1 check("reset A bus_out", a_bus_out, 8'h00);
    check("reset A pc", a_pc, 8'h00);
    check("reset B fault", b_fault, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Fill both RAMs; the DEPTH=200 instance faults on the upper addresses.
    for (int a = 0; a < 256; a++) begin
      step(OP_SET, 1'b0, 8'(a), 1'b0);
      step(OP_WRITE, 1'b0, 8'((a * 7 + 3) % 256), 1'b0);
    end
    check("fill B fault", b_fault, 1'b1);
    pulse_reset();

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].op, vecs[i].dws, vecs[i].bin, vecs[i].bsel);
      check($sformatf("vec%0d bus_out", i), a_bus_out, vecs[i].exp_out);
      check($sformatf("vec%0d pc", i), a_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d fault", i), a_fault, vecs[i].exp_fault);
      check($sformatf("vec%0d bus_oe", i), a_bus_oe, vecs[i].bsel);
    end

    // Out-of-range write on DEPTH=200 must not disturb in-range contents.
    pulse_reset();
    step(OP_SET, 1'b0, 8'hC8, 1'b0);
    step(OP_WRITE, 1'b0, 8'h77, 1'b0);
    check("oor write B fault", b_fault, 1'b1);
    check("oor write A fault", a_fault, 1'b0);
    step(OP_SET, 1'b0, 8'h00, 1'b0);
    step(OP_READ, 1'b0, 8'h00, 1'b1);
    check("oor preserved B", b_bus_out, 8'h11);
    step(OP_SET, 1'b0, 8'hC8, 1'b0);
    step(OP_READ, 1'b0, 8'h00, 1'b1);
    check("oor read B", b_bus_out, 8'h00);
    check("in-range read A", a_bus_out, 8'h77);

    // Asynchronous reset mid-cycle, with a WRITE on the bus that must be ignored.
    step(OP_JUMP, 1'b0, 8'h42, 1'b0);
    check("pre-reset A pc", a_pc, 8'h42);
    check("pre-reset B fault", b_fault, 1'b1);
    #2;
    reset_n = 1'b0;
    memory_op = MEM_WRITE;
    data_word_selector = 1'b0;
    bus_in = 8'hEE;
    model_reset();
    #1;
    check("async reset A pc", a_pc, 8'h00);
    check("async reset A bus_out", a_bus_out, 8'h00);
    check("async reset B fault", b_fault, 1'b0);
    check("async reset B pc", b_pc, 8'h00);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step(OP_READ, 1'b0, 8'h00, 1'b0);
    check("no write in reset A", a_bus_out, 8'h11);
    check("no write in reset B", b_bus_out, 8'h11);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Responder side of the control unit's memory interface. Each cycle it executes the `memory_op` command issued by the microcoded control unit. It holds the program counter (PC) and memory address register (MAR), reads and writes a synchronous byte RAM, and returns read/fetch data to the shared 8-bit bus. Instruction fetch (`MEM_FETCH`) feeds the control unit's instruction load.

## Interface
- `ADDR_WIDTH`, default 8: width of PC and MAR.
- `DEPTH`, default 256: implemented RAM bytes. Must satisfy DEPTH ≤ 2^ADDR_WIDTH. Addresses ≥ DEPTH are out of range.
- `clock`  in  1: single clock. All state updates on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `memory_op`  in  3 (`memory_op_e`): command, sampled at posedge. Encoding:
  - 0 `MEM_NOP`
  - 1 `MEM_READ`
  - 2 `MEM_WRITE`
  - 3 `MEM_SET_ADDR`
  - 4 `MEM_FETCH`
  - 5 `MEM_JUMP`
  - 6 `MEM_PC_INC`
  - 7 reserved, treated as NOP.
- `data_word_selector`  in  1: address source for READ/WRITE. 0 = MAR, 1 = PC.
- `bus_selector`  in  1: 1 = memory unit drives the bus this cycle.
- `bus_in`  in  8: bus value for WRITE, SET_ADDR and JUMP.
- `bus_out`  out  8: registered read data.
- `bus_oe`  out  1: drive enable onto the shared bus.
- `pc`  out  ADDR_WIDTH: current program counter.
- `mem_fault`  out  1: sticky out-of-range access flag.

## Operation
- Control-word outputs change on negedge, so the inputs above are stable at each posedge. The unit acts on exactly one command per posedge.
- `MEM_READ`: data_q <= ram[sel_addr].
- `MEM_WRITE`: ram[sel_addr] <= bus_in. data_q is unchanged.
- `MEM_SET_ADDR`: mar <= bus_in[ADDR_WIDTH-1:0]. If ADDR_WIDTH > 8, zero-extend.
- `MEM_FETCH`: data_q <= ram[pc], then pc advances (see PC arithmetic). data_word_selector is ignored.
- `MEM_JUMP`: pc <= bus_in, zero-extended.
- `MEM_PC_INC`: pc advances, no RAM access.
- `MEM_NOP` and reserved encodings: no state change.
- `sel_addr` = data_word_selector ? pc : mar.
- PC arithmetic:
  - pc_next = (pc == DEPTH-1) ? 0 : pc + 1.
  - Wrap-around is silent and does not set mem_fault.
  - If pc ≥ DEPTH (reached via JUMP), FETCH and PC_INC still advance pc modulo 2^ADDR_WIDTH.
- Out-of-range access: a READ, WRITE or FETCH whose effective address is ≥ DEPTH:
  - suppresses the RAM write;
  - loads data_q with 8'h00;
  - sets mem_fault.
  - FETCH still advances pc.
  - mem_fault stays 1 until reset.
- `bus_out` = data_q.
- `bus_oe` = bus_selector, combinational. The unit does not check whether data_q is fresh; the microcode sequences READ/FETCH one state before asserting bus_selector.
- The unit never drives the bus when bus_selector = 0.
- RAM contents are not reset.
- Reset values: pc=0, mar=0, data_q=0 (bus_out=8'h00), mem_fault=0. bus_oe follows bus_selector.

## Timing
- READ/FETCH latency is 1 cycle: data appears on bus_out after the posedge that samples the command and holds until the next READ/FETCH.
- WRITE takes effect at the sampling posedge. A READ of the same address on the next cycle returns the new value.
- A WRITE with data_word_selector=1 followed by FETCH on the next cycle returns the written byte; pc is not advanced by the WRITE.
- JUMP then FETCH on consecutive cycles: FETCH uses the jumped-to pc.
- SET_ADDR then READ on consecutive cycles: READ uses the new MAR.
- Asynchronous reset:
  - reset_n low clears pc, mar, data_q and mem_fault immediately, without waiting for a clock.
  - A posedge while reset_n is low performs no RAM write and no register update.
  - The first command executes at the first posedge after reset_n is high.

## Test plan
- Reset: drive reset_n low mid-run with pc=0x42 and mem_fault=1 -> pc=0, bus_out=8'h00 and mem_fault=0 before the next posedge.
- Write/read via MAR: SET_ADDR 0x10, WRITE 0xA5, READ, then bus_selector=1 -> bus_out=0xA5 and bus_oe=1 one cycle after READ; mem_fault=0.
- Fetch stream:
  - write 0x11, 0x22, 0x33 to addresses 0..2 via MAR;
  - JUMP 0x00, then three FETCH -> bus_out = 0x11, 0x22, 0x33 on successive cycles; pc=3.
- PC wrap: DEPTH=256, JUMP 0xFF, FETCH -> bus_out=ram[0xFF], pc=0x00, mem_fault=0.
- Out of range: DEPTH=200:
  - SET_ADDR 0xC8, WRITE 0x77 -> mem_fault=1;
  - SET_ADDR 0x00, READ -> earlier RAM contents preserved;
  - READ at 0xC8 -> bus_out=0x00.
- Write-then-fetch hazard: pc=5, WRITE 0x9C with data_word_selector=1, then FETCH -> bus_out=0x9C, pc=6.
